// File: rtl/signtrunc_pipe.sv
// Streaming signed narrower: arithmetic shift right by SHIFT, saturate to OUT_W, count clips.
// Optional macro SIGNTRUNC_ROUND_EN selects round-half-up instead of floor before saturation.
module signtrunc_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic [CNT_W-1:0] sat_count,
    input  logic             clr_count
);
    // Handshake: a transfer happens on a rising edge where valid && ready; a source holds
    // its payload while valid is high and ready is low, and ready never waits on valid.

    // One extra bit of headroom so the rounding offset cannot wrap a max-positive input.
    localparam int SW = IN_W + 1;

    localparam logic signed [SW-1:0] Q_MAX = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] Q_MIN = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0]     O_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]     O_MIN = {1'b1, {(OUT_W-1){1'b0}}};

`ifdef SIGNTRUNC_ROUND_EN
    localparam logic signed [SW-1:0] RND_ADD =
        (SHIFT > 0) ? (SW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`else
    localparam logic signed [SW-1:0] RND_ADD = '0;
`endif

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   data_q, data_d;
    logic               sat_q, sat_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               in_xfer;
    logic               out_xfer;
    logic signed [SW-1:0] s_ext;
    logic signed [SW-1:0] s_rnd;
    logic signed [SW-1:0] q_val;
    logic [OUT_W-1:0]   res_data;
    logic               res_sat;

    // Output-register occupancy: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
        end
    end

    // Occupancy: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (in_xfer) state_d = ST_FULL;
            ST_FULL:  if (out_xfer && !in_xfer) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Occupancy: outputs
    always_comb begin
        out_valid = (state_q == ST_FULL);
        in_ready  = !out_valid || out_ready;
    end

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        s_ext    = {in_data[IN_W-1], in_data};
        s_rnd    = s_ext + RND_ADD;
        q_val    = s_rnd >>> SHIFT;
        res_data = q_val[OUT_W-1:0];
        res_sat  = 1'b0;
        if (q_val > Q_MAX) begin
            res_data = O_MAX;
            res_sat  = 1'b1;
        end else if (q_val < Q_MIN) begin
            res_data = O_MIN;
            res_sat  = 1'b1;
        end
    end

    always_comb begin
        data_d = data_q;
        sat_d  = sat_q;
        if (in_xfer) begin
            data_d = res_data;
            sat_d  = res_sat;
        end
    end

    // Clear takes effect first so a clip in the same cycle leaves the count at one.
    always_comb begin
        cnt_d = clr_count ? '0 : cnt_q;
        if (in_xfer && res_sat && (cnt_d != {CNT_W{1'b1}})) begin
            cnt_d = cnt_d + CNT_W'(1);
        end
    end

    assign out_data  = data_q;
    assign out_sat   = sat_q;
    assign sat_count = cnt_q;

endmodule

// File: tb/tb_signtrunc_pipe.sv
// Bench for signtrunc_pipe: directed boundary cases plus randomized traffic scored against
// an arithmetic reference model; a second instance with a 2-bit counter exercises saturation.
module tb_signtrunc_pipe;
    localparam int IN_W   = 16;
    localparam int OUT_W  = 8;
    localparam int SHIFT  = 4;
    localparam int CNT_W  = 16;
    localparam int CNT2_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic              clr_count = 1'b0;
    logic [IN_W-1:0]   in_data = '0;
    logic              in_ready, out_valid, out_sat;
    logic [OUT_W-1:0]  out_data;
    logic [CNT_W-1:0]  sat_count;
    logic              in_ready2, out_valid2, out_sat2;
    logic [OUT_W-1:0]  out_data2;
    logic [CNT2_W-1:0] sat_count2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [OUT_W:0] exp_q[$];
    longint         exp_cnt  = 0;
    longint         exp_cnt2 = 0;

    signtrunc_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .sat_count(sat_count), .clr_count(clr_count)
    );

    signtrunc_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .CNT_W(CNT2_W)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_sat(out_sat2), .sat_count(sat_count2), .clr_count(clr_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    endtask

    // Reference: real floor division of the (optionally rounded) value, then clamp.
    function automatic logic [OUT_W:0] model(input logic [IN_W-1:0] d);
        longint s, q, hi, lo, div;
        s   = longint'($signed(d));
        div = longint'(1) << SHIFT;
`ifdef SIGNTRUNC_ROUND_EN
        s   = s + div / 2;
`endif
        if (s >= 0) q = s / div;
        else        q = -((-s + div - 1) / div);
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -hi - 1;
        if (q > hi) return {1'b1, OUT_W'(hi)};
        if (q < lo) return {1'b1, OUT_W'(lo)};
        return {1'b0, OUT_W'(q)};
    endfunction

    // ---------------- stimulus recorder: push expectations at each input transfer ----------------
    always @(negedge clk) begin
        logic [OUT_W:0] r;
        if (rst_n) begin
            check("sat_count", sat_count, exp_cnt);
            check("sat_count2", sat_count2, exp_cnt2);
            if (clr_count) begin
                exp_cnt  = 0;
                exp_cnt2 = 0;
            end
            if (in_valid && in_ready) begin
                r = model(in_data);
                exp_q.push_back(r);
                if (r[OUT_W]) begin
                    if (exp_cnt < (longint'(1) << CNT_W) - 1) exp_cnt++;
                    if (exp_cnt2 < (longint'(1) << CNT2_W) - 1) exp_cnt2++;
                end
            end
        end
    end

    // ---------------- monitor: pop and compare at each output transfer ----------------
    logic           stall_prev = 1'b0;
    logic [OUT_W:0] held = '0;

    always @(negedge clk) begin
        logic [OUT_W:0] e;
        #2;
        if (rst_n) begin
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {out_sat, out_data}, held);
            end
            check("in_ready", in_ready, !out_valid || out_ready);
            stall_prev = out_valid && !out_ready;
            held       = {out_sat, out_data};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[OUT_W-1:0]);
                    check("out_sat", out_sat, e[OUT_W]);
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [IN_W-1:0] d);
        bit took;
        took     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50 && !took; i++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!took) check("send_timeout", 0, 1);
    endtask

    task automatic send_expect(input string name, input logic [IN_W-1:0] d,
                               input logic [OUT_W-1:0] ed, input logic es);
        send(d);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_data"}, out_data, ed);
        check({name, "_sat"}, out_sat, es);
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        exp_cnt  = 0;
        exp_cnt2 = 0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_sat_count", sat_count, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [IN_W-1:0] d;
        int              v;
        bit              pend;

        #2;
        do_reset();
        idle(1);

        // Positive bound and first clip
        send_expect("pos_bound", 16'h07F0, 8'h7F, 1'b0);
        send_expect("pos_clip", 16'h0800, 8'h7F, 1'b1);
        check("first_clip_count", sat_count, 1);

        // Negative bound, negative clip, small negative
        send_expect("neg_bound", 16'hF800, 8'h80, 1'b0);
        send_expect("neg_clip", 16'hF7F0, 8'h80, 1'b1);
`ifdef SIGNTRUNC_ROUND_EN
        send_expect("minus_one", 16'hFFFF, 8'h00, 1'b0);
        send_expect("frac", 16'h0018, 8'h02, 1'b0);
        send_expect("max_pos", 16'h7FFF, 8'h7F, 1'b1);
`else
        send_expect("minus_one", 16'hFFFF, 8'hFF, 1'b0);
        send_expect("frac", 16'h0018, 8'h01, 1'b0);
        send_expect("max_pos", 16'h7FFF, 8'h7F, 1'b1);
`endif
        idle(2);

        // Backpressure: first output held for three cycles, nothing lost
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0010;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_data   = 16'h0020;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_data", out_data, 8'h01);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        send_expect("release_2", 16'h0020, 8'h02, 1'b0);
        send_expect("release_3", 16'h0030, 8'h03, 1'b0);
        idle(2);

        // Clear coinciding with a clip, then counter saturation on the narrow instance
        clr_count = 1'b1;
        send(16'h0800);
        clr_count = 1'b0;
        check("clr_and_clip", sat_count, 1);
        check("clr_and_clip2", sat_count2, 1);
        repeat (5) send(16'h8000);
        check("count_after_5", sat_count, 6);
        check("count2_saturated", sat_count2, 3);
        idle(2);

        // Reset while an output is stalled
        out_ready = 1'b0;
        send(16'h0800);
        check("pre_reset_valid", out_valid, 1);
        do_reset();
        out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("post_reset_no_leak", out_valid, 0);
        end

        // Randomized traffic with random backpressure and occasional clears
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            pend = in_valid && !in_ready;
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            clr_count = ($urandom_range(0, 40) == 0);
            if (!pend) begin
                case ($urandom_range(0, 3))
                    0: d = 16'($urandom);
                    1: begin v = 2016 + int'($urandom_range(0, 64)); d = 16'(v); end
                    2: begin v = int'($urandom_range(0, 64)) - 2080; d = 16'(v); end
                    default: begin
                        case ($urandom_range(0, 3))
                            0: d = 16'h7FFF;
                            1: d = 16'h8000;
                            2: d = 16'h0000;
                            default: d = 16'hFFFF;
                        endcase
                    end
                endcase
                in_data  = d;
                in_valid = ($urandom_range(0, 3) != 0);
            end
        end
        clr_count = 1'b0;
        idle(6);
        check("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
